// File: rtl/bk_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung adder.
package bk_adder_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Number of prefix levels: log2 up-sweep levels plus log2-1 down-sweep levels.
    function automatic int unsigned bk_levels(input int unsigned width);
        return 2 * $clog2(width) - 1;
    endfunction

    // Input register plus one register after every lps prefix levels.
    function automatic int unsigned bk_nstg(input int unsigned width, input int unsigned lps);
        return (bk_levels(width) + lps - 1) / lps + 1;
    endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// One combinational Brent-Kung prefix level: up-sweep for LEVEL < log2(WIDTH), down-sweep after.
module bk_prefix_level
    import bk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned LEVEL = 0
) (
    input  pg_t [WIDTH-1:0] pg_in,
    output pg_t [WIDTH-1:0] pg_out
);

    localparam int  N    = $clog2(WIDTH);
    localparam bit  UP   = (int'(LEVEL) < N);
    localparam int  J    = UP ? int'(LEVEL) : 2 * N - 2 - int'(LEVEL);
    localparam int  SPAN = 1 << J;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        // Down-sweep fills the odd multiples of SPAN left open by the up-sweep.
        localparam bit ACTIVE = UP ? (((i + 1) % (2 * SPAN)) == 0)
                                   : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN));
        if (ACTIVE) begin : g_op
            assign pg_out[i].g = pg_in[i].g | (pg_in[i].p & pg_in[i-SPAN].g);
            assign pg_out[i].p = pg_in[i].p & pg_in[i-SPAN].p;
        end else begin : g_pass
            assign pg_out[i] = pg_in[i];
        end
    end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// Define BK_ADD_OVF_EN to add the registered signed-overflow output out_ovf.
module bk_adder_pipe
    import bk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned LPS   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_pairs,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_sum
`ifdef BK_ADD_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    localparam int unsigned L    = bk_levels(WIDTH);
    localparam int unsigned NSTG = bk_nstg(WIDTH, LPS);
    localparam int unsigned NPG  = NSTG - 1;

    logic [NSTG-1:0]  v_q;
    logic [NSTG-1:0]  v_in;
    logic [NSTG-1:0]  ld;
    logic [WIDTH-1:0] a_c;
    logic [WIDTH-1:0] bx_c;
    pg_t  [WIDTH-1:0] fin_c;
    logic [WIDTH-1:0] c_c;
    logic [WIDTH-1:0] unused_grp_p;
    logic [WIDTH:0]   sum_c;
    logic             out_load_c;

    // Stage k loads when it is empty or every stage downstream of it can move.
    for (genvar k = 0; k < int'(NSTG); k++) begin : g_ready
        assign ld[k] = out_ready | ~(&v_q[NSTG-1:k]);
    end

    assign v_in       = {v_q[NSTG-2:0], in_valid};
    assign in_ready   = ld[0];
    assign out_valid  = v_q[NSTG-1];
    assign out_load_c = ld[NSTG-1] & v_in[NSTG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= (v_in & ld) | (v_q & ~ld);
        end
    end

    // Deinterleave operands; b is inverted for subtraction.
    always_comb begin
        a_c  = '0;
        bx_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            a_c[i]  = in_pairs[2*i];
            bx_c[i] = in_pairs[2*i+1] ^ in_sub;
        end
    end

    for (genvar s = 0; s < int'(NPG); s++) begin : g_stage
        pg_t  [WIDTH-1:0] pg_d;
        pg_t  [WIDTH-1:0] pg_q;
        logic [WIDTH-1:0] po_d;
        logic [WIDTH-1:0] po_q;
        logic             cin_d;
        logic             cin_q;

        if (s == 0) begin : g_src
            always_comb begin
                pg_d = '0;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    pg_d[i].p = a_c[i] ^ bx_c[i];
                    pg_d[i].g = a_c[i] & bx_c[i];
                end
            end
            assign po_d  = a_c ^ bx_c;
            assign cin_d = in_sub;
        end else begin : g_src
            assign pg_d  = g_level[s*LPS-1].dst;
            assign po_d  = g_stage[s-1].po_q;
            assign cin_d = g_stage[s-1].cin_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pg_q  <= '0;
                po_q  <= '0;
                cin_q <= 1'b0;
            end else if (ld[s] && v_in[s]) begin
                pg_q  <= pg_d;
                po_q  <= po_d;
                cin_q <= cin_d;
            end
        end
    end

    for (genvar l = 0; l < int'(L); l++) begin : g_level
        pg_t [WIDTH-1:0] src;
        pg_t [WIDTH-1:0] dst;

        if (l == 0) begin : g_src
            // Fold carry-in into bit 0 so every group generate already includes it.
            always_comb begin
                src      = g_stage[0].pg_q;
                src[0].g = g_stage[0].pg_q[0].g | (g_stage[0].pg_q[0].p & g_stage[0].cin_q);
            end
        end else if ((l % LPS) == 0) begin : g_src
            assign src = g_stage[l/LPS].pg_q;
        end else begin : g_src
            assign src = g_level[l-1].dst;
        end

        bk_prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (l)
        ) u_level (
            .pg_in  (src),
            .pg_out (dst)
        );
    end

    assign fin_c = g_level[L-1].dst;

    always_comb begin
        c_c          = '0;
        unused_grp_p = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c_c[i]          = fin_c[i].g;
            unused_grp_p[i] = fin_c[i].p;
        end
    end

    assign sum_c = {c_c[WIDTH-1], g_stage[NPG-1].po_q ^ {c_c[WIDTH-2:0], g_stage[NPG-1].cin_q}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
        end else if (out_load_c) begin
            out_sum <= sum_c;
        end
    end

`ifdef BK_ADD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (out_load_c) begin
            out_ovf <= c_c[WIDTH-1] ^ c_c[WIDTH-2];
        end
    end
`endif

endmodule
